wb_line_master: RTL and testbench

- Wishbone classic initiator: turns CPU/cache-side requests into bus cycles toward memory-mapped responders (DRAM controller, peripherals).
- Two request kinds:
  - Line read: LINE_WORDS sequential words in one held cyc_o cycle.
  - Single-word write.
- Read data streams back one word per beat; an optional watchdog stops a hung responder from stalling the core.

---
 rtl/wb_line_master.sv | 157 +++++++++++++++
 tb/tb_wb_line_master.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_line_master.sv
// Wishbone classic initiator: LINE_WORDS-beat line reads in one held cycle, single-word writes.
// Optional per-beat ack watchdog enabled by `define WB_MASTER_TIMEOUT_EN.
module wb_line_master #(
    parameter int LINE_WORDS     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_data_o,
    output logic        rsp_last_o,
    output logic        rsp_err_o,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [31:0] addr_o,
    output logic [31:0] data_o,
    input  logic [31:0] data_i,
    input  logic        ack_i
);
    localparam int          BW        = $clog2(LINE_WORDS);
    localparam logic [31:0] LINE_MASK = ~(32'(LINE_WORDS * 4) - 32'd1);

    if (LINE_WORDS < 2 || LINE_WORDS > 16 || (LINE_WORDS & (LINE_WORDS - 1)) != 0) begin : g_bad_line
        $error("LINE_WORDS must be a power of two in 2..16");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic {IDLE, BUS} state_t;

    state_t        state_q;
    logic          ready_q, cyc_q, stb_q, we_q;
    logic [31:0]   addr_q, data_q;
    logic          rsp_valid_q, rsp_last_q;
    logic [31:0]   rsp_data_q;
    logic [BW-1:0] beat_q;

    logic          last_beat_d;
    logic [31:0]   req_addr_d;

    // A write is always its own final beat.
    assign last_beat_d = we_q || (beat_q == BW'(LINE_WORDS - 1));
    assign req_addr_d  = req_we_i ? (req_addr_i & ~32'd3) : (req_addr_i & LINE_MASK);

`ifdef WB_MASTER_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WW-1:0] wdog_q;
    logic          rsp_err_q;
    logic          wdog_expired_d;
    assign wdog_expired_d = (wdog_q == WW'(TIMEOUT_CYCLES));
    assign rsp_err_o      = rsp_err_q;
`else
    assign rsp_err_o = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ready_q     <= 1'b1;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_data_q  <= '0;
            beat_q      <= '0;
`ifdef WB_MASTER_TIMEOUT_EN
            wdog_q      <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_data_q  <= '0;
`ifdef WB_MASTER_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        state_q <= BUS;
                        ready_q <= 1'b0;
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                        we_q    <= req_we_i;
                        addr_q  <= req_addr_d;
                        data_q  <= req_we_i ? req_wdata_i : 32'd0;
                        beat_q  <= '0;
`ifdef WB_MASTER_TIMEOUT_EN
                        wdog_q  <= '0;
`endif
                    end
                end
                BUS: begin
                    if (ack_i) begin
                        rsp_valid_q <= 1'b1;
                        rsp_last_q  <= last_beat_d;
                        rsp_data_q  <= we_q ? 32'd0 : data_i;
`ifdef WB_MASTER_TIMEOUT_EN
                        wdog_q      <= '0;
`endif
                        if (last_beat_d) begin
                            state_q <= IDLE;
                            ready_q <= 1'b1;
                            cyc_q   <= 1'b0;
                            stb_q   <= 1'b0;
                            we_q    <= 1'b0;
                            data_q  <= '0;
                            beat_q  <= '0;
                        end else begin
                            addr_q <= addr_q + 32'd4;
                            beat_q <= beat_q + 1'b1;
                        end
                    end
`ifdef WB_MASTER_TIMEOUT_EN
                    // Hung responder: abandon the remaining beats with one error response.
                    else if (wdog_expired_d) begin
                        rsp_valid_q <= 1'b1;
                        rsp_last_q  <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        state_q     <= IDLE;
                        ready_q     <= 1'b1;
                        cyc_q       <= 1'b0;
                        stb_q       <= 1'b0;
                        we_q        <= 1'b0;
                        data_q      <= '0;
                        beat_q      <= '0;
                        wdog_q      <= '0;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready_o = ready_q;
    assign cyc_o       = cyc_q;
    assign stb_o       = stb_q;
    assign we_o        = we_q;
    assign addr_o      = addr_q;
    assign data_o      = data_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_last_o  = rsp_last_q;
    assign rsp_data_o  = rsp_data_q;
endmodule

// File: tb/tb_wb_line_master.sv
// Bench for wb_line_master: transaction-level model checked every cycle, a delay-programmable
// responder, directed literal cases and a randomized request stream.
module tb_wb_line_master;
    localparam int LW = 4;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid_i, req_we_i;
    logic [31:0] req_addr_i, req_wdata_i, data_i;
    logic        ack_i;
    logic        req_ready_o, rsp_valid_o, rsp_last_o, rsp_err_o;
    logic        cyc_o, stb_o, we_o;
    logic [31:0] rsp_data_o, addr_o, data_o;

    wb_line_master #(.LINE_WORDS(LW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_last_o(rsp_last_o),
        .rsp_err_o(rsp_err_o), .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o),
        .addr_o(addr_o), .data_o(data_o), .data_i(data_i), .ack_i(ack_i)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Responder: per-beat ack delay from dq (-1 = never ack), random 0..3 when dq is empty.
    int dq[$];
    bit have;
    int cur, wcnt;
    initial begin
        ack_i = 1'b0; data_i = '0; have = 1'b0; cur = 0; wcnt = 0;
        forever begin
            @(posedge clk); #1;
            if (cyc_o && stb_o) begin
                if (!have) begin
                    cur  = (dq.size() > 0) ? dq.pop_front() : int'($urandom_range(3, 0));
                    have = 1'b1;
                    wcnt = 0;
                end
                if (cur >= 0 && wcnt == cur) begin
                    ack_i  = 1'b1;
                    data_i = addr_o ^ 32'hA5A5A5A5;
                    have   = 1'b0;
                end else begin
                    ack_i  = 1'b0;
                    data_i = $urandom;
                    wcnt++;
                end
            end else begin
                ack_i  = 1'($urandom_range(1, 0));
                data_i = $urandom;
                have   = 1'b0;
            end
        end
    end

    // Monitor: logs accepted beats, responses and the length of cyc_o idle gaps.
    logic [31:0] acc_addr[$];
    logic [32:0] acc_wd[$];
    logic [33:0] rsp_log[$];
    int rsp_cnt = 0, low_run = 0, last_gap = -1;
    initial forever begin
        @(negedge clk);
        if (cyc_o && stb_o && ack_i) begin
            acc_addr.push_back(addr_o);
            acc_wd.push_back({we_o, data_o});
        end
        if (rsp_valid_o) begin
            rsp_log.push_back({rsp_last_o, rsp_err_o, rsp_data_o});
            rsp_cnt++;
        end
        if (!cyc_o) low_run++;
        else begin
            if (low_run > 0) last_gap = low_run;
            low_run = 0;
        end
    end

    // Reference model: one outstanding request, beat index and ack-less cycle count.
    bit          m_busy, m_we, e_vld, e_last, e_err;
    int          m_idx, m_wait;
    logic [31:0] m_base, m_wdata, e_data;
    initial begin
        m_busy = 0; m_we = 0; m_idx = 0; m_wait = 0; m_base = '0; m_wdata = '0;
        e_vld = 0; e_last = 0; e_err = 0; e_data = '0;
        forever begin
            @(posedge clk);
            e_vld = 0; e_last = 0; e_err = 0; e_data = '0;
            if (!rst_n) m_busy = 0;
            else if (!m_busy) begin
                if (req_valid_i) begin
                    m_busy  = 1;
                    m_we    = req_we_i;
                    m_wdata = req_wdata_i;
                    m_idx   = 0;
                    m_wait  = 0;
                    m_base  = req_we_i ? (req_addr_i & ~32'd3) : (req_addr_i & ~(32'(LW * 4) - 32'd1));
                end
            end else if (ack_i) begin
                e_vld  = 1;
                e_data = m_we ? 32'd0 : data_i;
                e_last = m_we || (m_idx == LW - 1);
                if (e_last) m_busy = 0;
                else begin
                    m_idx++;
                    m_wait = 0;
                end
            end else begin
`ifdef WB_MASTER_TIMEOUT_EN
                if (m_wait == TO) begin
                    e_vld = 1; e_err = 1; e_last = 1; m_busy = 0;
                end else
`endif
                m_wait++;
            end
            @(negedge clk);
            chk("bus", {req_ready_o, cyc_o, stb_o, we_o, m_busy ? addr_o : 32'h0, m_busy ? data_o : 32'h0},
                m_busy ? {1'b0, 1'b1, 1'b1, m_we, m_base + 32'(4 * m_idx), m_we ? m_wdata : 32'h0}
                       : {1'b1, 3'b000, 64'h0});
            chk("rsp", {rsp_valid_o, rsp_valid_o ? {rsp_last_o, rsp_err_o, rsp_data_o} : 34'h0},
                {e_vld, e_vld ? {e_last, e_err, e_data} : 34'h0});
        end
    end

    task automatic rand_fields();
        req_we_i    = 1'($urandom_range(1, 0));
        req_addr_i  = $urandom;
        req_wdata_i = $urandom;
    endtask

    task automatic wait_accept();
        bit got = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (req_ready_o) begin
                got = 1;
                break;
            end
        end
        @(posedge clk); #1;
        chk("accept_wait", 128'(got), 128'd1);
    endtask

    task automatic do_req(input bit we, input logic [31:0] a, input logic [31:0] d);
        req_we_i = we; req_addr_i = a; req_wdata_i = d; req_valid_i = 1'b1;
        wait_accept();
        req_valid_i = 1'b0;
        rand_fields();
    endtask

    task automatic wait_idle();
        bit got = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (!cyc_o && req_ready_o) begin
                got = 1;
                break;
            end
        end
        chk("idle_wait", 128'(got), 128'd1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        acc_addr.delete(); acc_wd.delete(); rsp_log.delete(); dq.delete();
    endtask

    logic [31:0] rd_addr_exp[4] = '{32'h1230, 32'h1234, 32'h1238, 32'h123C};
    logic [31:0] rd_data_exp[4] = '{32'hA5A5B795, 32'hA5A5B791, 32'hA5A5B79D, 32'hA5A5B799};
    logic [31:0] wr_addr_exp[4] = '{32'hFFFFFFF0, 32'hFFFFFFF4, 32'hFFFFFFF8, 32'hFFFFFFFC};
    int base, n;

    initial begin
        rst_n = 1'b0; req_valid_i = 1'b0; rand_fields();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {req_ready_o, rsp_valid_o, rsp_data_o, rsp_last_o, rsp_err_o,
                            cyc_o, stb_o, we_o, addr_o, data_o}, {1'b1, 102'b0});
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Line read, responder acks one cycle after each strobe.
        clear_logs(); dq = '{1, 1, 1, 1};
        do_req(1'b0, 32'h00001234, 32'h0);
        wait_idle();
        chk("rd_beats", 128'(acc_addr.size()), 128'd4);
        chk("rd_rsps", 128'(rsp_log.size()), 128'd4);
        if (acc_addr.size() == 4 && rsp_log.size() == 4)
            for (int i = 0; i < 4; i++) begin
                chk("rd_addr", acc_addr[i], rd_addr_exp[i]);
                chk("rd_rsp", rsp_log[i], {i == 3, 1'b0, rd_data_exp[i]});
            end

        // Single write acked in the first bus cycle.
        clear_logs(); dq = '{0};
        do_req(1'b1, 32'h00002006, 32'hDEADBEEF);
        @(negedge clk); chk("wr_ready_busy", 128'(req_ready_o), 128'd0);
        @(posedge clk);
        @(negedge clk); chk("wr_ready_back", 128'(req_ready_o), 128'd1);
        wait_idle();
        chk("wr_beats", 128'(acc_addr.size()), 128'd1);
        chk("wr_rsps", 128'(rsp_log.size()), 128'd1);
        if (acc_addr.size() == 1 && rsp_log.size() == 1) begin
            chk("wr_addr", acc_addr[0], 32'h2004);
            chk("wr_we_data", acc_wd[0], {1'b1, 32'hDEADBEEF});
            chk("wr_rsp", rsp_log[0], {1'b1, 1'b0, 32'h0});
        end

        // Back-to-back: second request held valid during the first read.
        clear_logs();
        req_we_i = 1'b0; req_addr_i = 32'h3000; req_valid_i = 1'b1;
        wait_accept();
        req_addr_i = 32'h3040;
        wait_accept();
        req_valid_i = 1'b0;
        wait_idle();
        chk("b2b_gap", 128'(last_gap), 128'd1);
        chk("b2b_beats", 128'(acc_addr.size()), 128'd8);
        if (acc_addr.size() == 8) chk("b2b_second_addr", acc_addr[4], 32'h3040);

        // Reset right after the second beat's response.
        clear_logs(); dq = '{1, 1, 1, 1};
        base = rsp_cnt; n = 0;
        do_req(1'b0, 32'h00004000, 32'h0);
        for (int i = 0; i < 100 && n < 2; i++) begin
            @(posedge clk); #1;
            if (rsp_valid_o) n++;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid", {cyc_o, stb_o, req_ready_o, rsp_valid_o}, 4'b0010);
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("rst_rsp_count", 128'(rsp_cnt - base), 128'd2);

        // Ack arriving exactly in the watchdog expiry cycle is a normal beat.
        clear_logs(); dq = '{1, TO, 1, 1};
        do_req(1'b0, 32'h00000100, 32'h0);
        wait_idle();
        chk("exp_rsps", 128'(rsp_log.size()), 128'd4);
        if (rsp_log.size() == 4) begin
            chk("exp_beat1", rsp_log[1], {1'b0, 1'b0, 32'hA5A5A4A1});
            chk("exp_last", rsp_log[3][33:32], 2'b10);
        end

`ifdef WB_MASTER_TIMEOUT_EN
        clear_logs(); dq = '{1, -1};
        do_req(1'b0, 32'h00000200, 32'h0);
        wait_idle();
        chk("to_rsps", 128'(rsp_log.size()), 128'd2);
        if (rsp_log.size() == 2) begin
            chk("to_beat0", rsp_log[0], {1'b0, 1'b0, 32'hA5A5A7A5});
            chk("to_err", rsp_log[1], {1'b1, 1'b1, 32'h0});
        end
`endif

        // Line at the top of the address space, mixed ack delays.
        clear_logs(); dq = '{0, 3, 7, 0};
        do_req(1'b0, 32'hFFFFFFF4, 32'h0);
        wait_idle();
        chk("top_beats", 128'(acc_addr.size()), 128'd4);
        if (acc_addr.size() == 4 && rsp_log.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("top_addr", acc_addr[i], wr_addr_exp[i]);
            chk("top_rsp0", rsp_log[0], {1'b0, 1'b0, 32'h5A5A5A55});
            chk("top_rsp3", rsp_log[3], {1'b1, 1'b0, 32'h5A5A5A59});
        end

        clear_logs();
        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(3, 0)) begin
                @(posedge clk); #1;
                rand_fields();
            end
            do_req(1'($urandom_range(1, 0)), $urandom, $urandom);
        end
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
